cfg_chain_loader: RTL and testbench
===================================

Name: cfg_chain_loader

Overview:
- Sequences the serial configuration chain of one PE block: holds a host-written bitstream, clears the chain, shifts the bitstream in, then shifts it through again to verify the chain end against the expected bits.
- Sits between the array-level configuration controller (word-wide host port) and the head and tail of a PE's config_cell / switch chain.
- Reports busy, done and error to the host.

Parameters:
- CHAIN_LEN, 14, total config bits in the target chain (≥1).
- WORD_W, 32, host write word width.
- DEPTH, 1, bitstream storage words. Must satisfy DEPTH*WORD_W ≥ CHAIN_LEN.
- AW, 1, word address width, = max(1, clog2(DEPTH)).

Ports:
- clk  in  1  single system clock. The chain also advances on clk, qualified by config_shift.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe.
- wr_addr  in  AW  bitstream word address.
- wr_data  in  WORD_W  bitstream word.
- start  in  1  one-cycle pulse that begins a clear/load/verify sequence.
- config_reset  out  1  chain clear pulse.
- config_shift  out  1  chain advance enable; one chain shift per high cycle.
- config_out  out  1  serial bit into the chain head.
- config_in  in  1  serial bit from the chain tail.
- busy  out  1  high from start acceptance until DONE/ERR exit.
- done  out  1  one-cycle pulse at the end of a sequence.
- error  out  1  sticky verify-mismatch flag.
- err_idx  out  clog2(CHAIN_LEN)+1  shift index of the first mismatch.

Behaviour:
- Reset (async): all outputs 0, state IDLE, bit counter 0, err_idx 0. Bitstream storage is also cleared to 0.
- Bitstream mapping: bit k = word[k/WORD_W][k%WORD_W]. Shift order is k = CHAIN_LEN-1 down to 0, so shift index i emits bit CHAIN_LEN-1-i.
- Storage writes: wr_en writes the word only in IDLE. Writes while busy are ignored. wr_addr ≥ DEPTH is ignored.
- IDLE:
  - start → CLEAR. Same edge: busy ← 1, error ← 0, err_idx ← 0.
  - start while busy is ignored.
- CLEAR:
  - Exactly one cycle with config_reset = 1; config_shift = 0.
  - Next state LOAD, counter i ← 0.
- LOAD:
  - config_shift = 1 every cycle; config_out = bit(CHAIN_LEN-1-i), driven combinationally from the counter.
  - i increments each cycle.
  - After the shift with i = CHAIN_LEN-1 → VERIFY, i ← 0.
  - Duration: exactly CHAIN_LEN cycles.
- VERIFY:
  - Same drive as LOAD: re-shifts the identical bitstream, so the chain ends holding it.
  - Each cycle, config_in is sampled (value present while config_shift is high, before the edge) and compared with bit(CHAIN_LEN-1-i).
  - On the first mismatch: error ← 1, err_idx ← i. Later mismatches do not update err_idx.
  - After i = CHAIN_LEN-1 → DONE.
- DONE:
  - One cycle: done = 1, busy = 0 on the following cycle, config_shift = 0. Then → IDLE.
  - error stays valid until the next accepted start.
- Latency: start accepted at edge t. config_reset is high in cycle t+1. Shifts occur in cycles t+2 … t+1+2·CHAIN_LEN. done is high in cycle t+2+2·CHAIN_LEN.
- config_shift and config_reset are never high in the same cycle. config_out is 0 whenever config_shift is 0.
- start coincident with wr_en in IDLE: the write completes and the sequence starts on the same edge; the new word is used.
- Reset asserted mid-sequence: immediate return to IDLE, all outputs 0. The chain contents are undefined; the host must restart.
- CHAIN_LEN not a multiple of WORD_W: unused high bits of the last word are never shifted.

Test Plan:
- Reset then idle (CHAIN_LEN=14): no start → config_shift, config_reset, busy, done, error all 0 for 20 cycles.
- Load/verify with a loopback model (14-bit shift register on clk&config_shift, cleared by config_reset, tail → config_in):
  - Stimulus: wr word0=0x00002A5C, pulse start.
  - config_reset high 1 cycle, then 28 shift cycles.
  - config_out sequence for the first 14 shifts = 0b10101001011100 (bit13→bit0).
  - done pulse at start+30, error=0; model register holds 0x2A5C.
- Stuck-at fault: tail forced to 0, word0=0x00002000 → error=1, err_idx=0 (VERIFY i=0 expects bit13=1), done still pulses at the normal time.
- Busy protection: start and wr_en (word0=0xFFFF) issued mid-LOAD → both ignored; sequence count unchanged; shifted data is the original word.
- Async reset at LOAD i=5 → outputs 0 immediately. A following start runs a full 30-cycle sequence and passes.
- Back-to-back: start in the cycle after done → a new sequence is accepted, and error from the previous failed run is cleared on acceptance.

Source files
------------

// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : cfg_chain_loader
// Description : Sequences the serial configuration chain of one PE block.
//               Holds a host-written bitstream, pulses a chain clear, shifts
//               the bitstream into the chain head, then shifts it through a
//               second time while comparing the chain tail against the
//               expected bits. The chain therefore ends holding the bitstream.
// Ports       : clk            system clock (the chain also advances on clk)
//               reset          asynchronous active-high reset
//               wr_en/wr_addr/wr_data  host bitstream word writes (IDLE only)
//               start          one-cycle pulse that begins a sequence
//               config_reset   chain clear pulse
//               config_shift   chain advance enable, one shift per cycle
//               config_out     serial bit into the chain head
//               config_in      serial bit from the chain tail
//               busy/done      sequence status
//               error/err_idx  sticky verify mismatch and its first index
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 14,
  parameter int WORD_W    = 32,
  parameter int DEPTH     = 1,
  parameter int AW        = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [WORD_W-1:0]            wr_data,
  input  logic                         start,
  output logic                         config_reset,
  output logic                         config_shift,
  output logic                         config_out,
  input  logic                         config_in,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(CHAIN_LEN):0]   err_idx
);

  // Counter width only has to span 0..CHAIN_LEN-1.
  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int IW = $clog2(CHAIN_LEN) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              error_q, error_d;
  logic [IW-1:0]     err_idx_q, err_idx_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [DEPTH*WORD_W-1:0] flat_w;
  logic [CHAIN_LEN-1:0]    seq_w;
  logic                    bit_w;
  logic                    last_w;
  logic                    unused_hi_w;

  // Flatten storage so bit k sits at flat_w[k].
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign flat_w[g*WORD_W +: WORD_W] = mem_q[g];
  end

  // seq_w[i] is the bit emitted at shift index i (MSB of the stream first).
  for (genvar g = 0; g < CHAIN_LEN; g++) begin : g_seq
    assign seq_w[g] = flat_w[CHAIN_LEN-1-g];
  end

  // High bits of the last word beyond CHAIN_LEN are stored but never shifted.
  assign unused_hi_w = ^flat_w;

  assign bit_w  = seq_w[cnt_q];
  assign last_w = (cnt_q == CW'(CHAIN_LEN-1));

  // --------------------------------------------------------------------------
  // Bitstream storage: writable only while idle; out-of-range addresses
  // match no word and are dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if ((state_q == S_IDLE) && wr_en) begin
      for (int w = 0; w < DEPTH; w++) begin
        if (wr_addr == AW'(w)) begin
          mem_q[w] <= wr_data;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    error_d      = error_q;
    err_idx_d    = err_idx_q;
    config_reset = 1'b0;
    config_shift = 1'b0;
    config_out   = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLEAR;
          error_d   = 1'b0;
          err_idx_d = '0;
        end
      end

      S_CLEAR: begin
        config_reset = 1'b1;
        cnt_d        = '0;
        state_d      = S_LOAD;
      end

      S_LOAD: begin
        config_shift = 1'b1;
        config_out   = bit_w;
        if (last_w) begin
          cnt_d   = '0;
          state_d = S_VERIFY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_VERIFY: begin
        // Re-shifting the same stream pushes the loaded copy out of the
        // tail one bit per cycle, so tail bit i must equal stream bit i.
        config_shift = 1'b1;
        config_out   = bit_w;
        if ((config_in != bit_w) && !error_q) begin
          error_d   = 1'b1;
          err_idx_d = IW'(cnt_q);
        end
        if (last_w) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign error   = error_q;
  assign err_idx = err_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_chain_loader
// Description : Directed self-checking bench for cfg_chain_loader with a
//               14-bit loopback chain model (optionally stuck-at-0 at the
//               tail). Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_chain_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        config_reset;
  logic        config_shift;
  logic        config_out;
  logic        config_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [4:0]  err_idx;

  logic [13:0] chain_m = '0;
  logic        stuck = 1'b0;

  int n_tot = 0;
  int n_bad = 0;

  cfg_chain_loader #(
    .CHAIN_LEN(14),
    .WORD_W   (32),
    .DEPTH    (1),
    .AW       (1)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .config_reset(config_reset),
    .config_shift(config_shift),
    .config_out  (config_out),
    .config_in   (config_in),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_idx     (err_idx)
  );

  always #5 clk = ~clk;

  // Loopback chain: head at bit 0, tail at bit 13.
  always @(posedge clk) begin
    if (config_reset) begin
      chain_m <= '0;
    end else if (config_shift) begin
      chain_m <= {chain_m[12:0], config_out};
    end
  end

  assign config_in = stuck ? 1'b0 : chain_m[13];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [0:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick;
    wr_en   = 1'b0;
  endtask

  // Runs one full sequence. Cycle 1 is the clear cycle, cycles 2..29 shift,
  // cycle 30 is done. Optionally writes word0 on the start edge, and
  // optionally fires a start + wr_en mid-LOAD that must be ignored.
  task automatic run_seq(input logic [13:0] exp_bits, input logic exp_err,
                         input logic [4:0] exp_idx, input logic wr_same,
                         input logic [31:0] wdata, input logic inject);
    logic [3:0] bi;
    start = 1'b1;
    if (wr_same) begin
      wr_en   = 1'b1;
      wr_addr = 1'b0;
      wr_data = wdata;
    end
    tick;
    start = 1'b0;
    wr_en = 1'b0;
    chk("clr_reset", 32'(config_reset), 32'd1);
    chk("clr_shift", 32'(config_shift), 32'd0);
    chk("acc_busy",  32'(busy),         32'd1);
    chk("acc_error", 32'(error),        32'd0);
    chk("acc_idx",   32'(err_idx),      32'd0);
    for (int c = 2; c <= 29; c++) begin
      tick;
      start = 1'b0;
      wr_en = 1'b0;
      bi = 4'(13 - ((c - 2) % 14));
      chk("shift_en",  32'(config_shift), 32'd1);
      chk("shift_rst", 32'(config_reset), 32'd0);
      chk("shift_bit", 32'(config_out),   32'(exp_bits[bi]));
      if (inject && c == 5) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 1'b0;
        wr_data = 32'h0000_FFFF;
      end
    end
    tick;
    chk("done_pulse", 32'(done),         32'd1);
    chk("done_shift", 32'(config_shift), 32'd0);
    chk("done_out",   32'(config_out),   32'd0);
    chk("done_busy",  32'(busy),         32'd1);
    chk("done_error", 32'(error),        32'(exp_err));
    chk("done_idx",   32'(err_idx),      32'(exp_idx));
    chk("chain_data", 32'(chain_m),      32'(exp_bits));
    tick;
    chk("post_done",  32'(done),  32'd0);
    chk("post_busy",  32'(busy),  32'd0);
    chk("post_error", 32'(error), 32'(exp_err));
  endtask

  initial begin
    // Reset and idle
    tick;
    tick;
    chk("rst_shift", 32'(config_shift), 32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_idx",   32'(err_idx),      32'd0);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick;
      chk("idle_outs", 32'({config_shift, config_reset, busy, done, error, config_out}), 32'd0);
    end

    // Nominal load/verify; out-of-range write must not disturb word0
    wr(1'b0, 32'h0000_2A5C);
    wr(1'b1, 32'h0000_3FFF);
    run_seq(14'h2A5C, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

    // Start and write issued mid-LOAD are both ignored
    run_seq(14'h2A5C, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    tick;
    chk("no_extra_seq", 32'({busy, config_reset, config_shift}), 32'd0);

    // Tail stuck at 0: first shifted bit (bit13=1) mismatches at index 0
    stuck = 1'b1;
    wr(1'b0, 32'h0000_2000);
    run_seq(14'h2000, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0);

    // Mismatches at indices 2 and 4; only the first is recorded
    wr(1'b0, 32'h0000_0A00);
    run_seq(14'h0A00, 1'b1, 5'd2, 1'b0, 32'd0, 1'b0);

    // Back-to-back start in the cycle after done, with a coincident write
    stuck = 1'b0;
    run_seq(14'h15A3, 1'b0, 5'd0, 1'b1, 32'h0000_15A3, 1'b0);

    // Async reset in LOAD at i=5, then a clean rerun from cleared storage
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      tick;
    end
    chk("pre_rst_shift", 32'(config_shift), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_outs", 32'({config_shift, config_reset, config_out, busy, done, error}), 32'd0);
    chk("arst_idx",  32'(err_idx), 32'd0);
    tick;
    reset = 1'b0;
    tick;
    run_seq(14'h0000, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
